// File: rtl/intc_seq.sv
// Interrupt sequencer: latches sources, masks, picks lowest index, handshakes with CP0.
// Build option INTC_LEVEL_EN selects level-sensitive sources instead of rising-edge latching.
module intc_seq #(
    parameter int unsigned NSRC      = 6,
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F20
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] irq_src,
    input  logic [31:0]     addr,
    input  logic            we,
    input  logic [31:0]     wdata,
    output logic [31:0]     rdata,
    input  logic            int_take,
    output logic            int_req,
    output logic [5:0]      hw_int
);

    typedef enum logic [1:0] {StIdle, StAssert, StService} state_e;

    state_e          state_q;
    logic [2:0]      sel_q;
    logic [NSRC-1:0] pend_q;
    logic [NSRC-1:0] mask_q;

    logic       hit;
    logic [1:0] reg_idx;
    logic       wr_ack;
    logic       wr_mask;
    logic       wr_pend;
    logic       ack_fire;

    assign hit      = (addr[31:4] == BASE_ADDR[31:4]);
    assign reg_idx  = addr[3:2];
    assign wr_ack   = we && hit && (reg_idx == 2'd0);
    assign wr_mask  = we && hit && (reg_idx == 2'd1);
    assign wr_pend  = we && hit && (reg_idx == 2'd2);
    assign ack_fire = wr_ack && (state_q == StService);

    // Padded copies so a 3-bit sel can index them for any legal NSRC.
    logic [7:0] pend8;
    logic [7:0] mask8;
    logic [7:0] sel_oh8;
    assign pend8   = 8'(pend_q);
    assign mask8   = 8'(mask_q);
    assign sel_oh8 = 8'd1 << sel_q;

    logic [NSRC-1:0] active;
    logic [2:0]      first_idx;
    assign active = pend_q & mask_q;

    always_comb begin
        first_idx = 3'd0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (active[i]) first_idx = 3'(i);
        end
    end

`ifdef INTC_LEVEL_EN
    logic unused_bits;
    assign unused_bits = ^{addr[1:0], wdata[31:NSRC], wr_pend, ack_fire, sel_oh8};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_q <= '0;
        end else begin
            pend_q <= irq_src;
        end
    end
`else
    logic [NSRC-1:0] prev_q;
    logic [NSRC-1:0] pend_set;
    logic [NSRC-1:0] pend_clr;
    logic            unused_bits;

    assign unused_bits = ^{addr[1:0], wdata[31:NSRC], sel_oh8[7:NSRC]};
    assign pend_set    = irq_src & ~prev_q;
    assign pend_clr    = (wr_pend ? wdata[NSRC-1:0] : '0)
                       | (ack_fire ? sel_oh8[NSRC-1:0] : '0);

    // A new rise wins over an ACK or W1C clear on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q <= '0;
            pend_q <= '0;
        end else begin
            prev_q <= irq_src;
            pend_q <= (pend_q & ~pend_clr) | pend_set;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask_q <= '1;
        end else if (wr_mask) begin
            mask_q <= wdata[NSRC-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            sel_q   <= 3'd0;
            int_req <= 1'b0;
            hw_int  <= 6'd0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (|active) begin
                        state_q <= StAssert;
                        sel_q   <= first_idx;
                        int_req <= 1'b1;
                        hw_int  <= 6'(8'd1 << first_idx);
                    end
                end
                StAssert: begin
                    // Take beats withdrawal when both happen on the same edge.
                    if (int_take) begin
                        state_q <= StService;
                        int_req <= 1'b0;
                        hw_int  <= 6'd0;
                    end else if (!mask8[sel_q] || !pend8[sel_q]) begin
                        state_q <= StIdle;
                        sel_q   <= 3'd0;
                        int_req <= 1'b0;
                        hw_int  <= 6'd0;
                    end
                end
                StService: begin
                    if (wr_ack) begin
                        state_q <= StIdle;
                        sel_q   <= 3'd0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    sel_q   <= 3'd0;
                    int_req <= 1'b0;
                    hw_int  <= 6'd0;
                end
            endcase
        end
    end

    always_comb begin
        rdata = 32'd0;
        if (hit) begin
            case (reg_idx)
                2'd1:    rdata = 32'(mask_q);
                2'd2:    rdata = 32'(pend_q);
                2'd3:    rdata = {(state_q == StService), 28'd0, sel_q};
                default: rdata = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_intc_seq.sv
// Directed bench for intc_seq: request, priority, mask, W1C/ACK races, reset, ignored strobes.
// Build with INTC_LEVEL_EN defined to exercise the level-sensitive variant instead.
module tb_intc_seq;

    localparam logic [31:0] BASE  = 32'h0000_7F20;
    localparam logic [31:0] A_ACK = BASE;
    localparam logic [31:0] A_MSK = BASE + 32'd4;
    localparam logic [31:0] A_PND = BASE + 32'd8;
    localparam logic [31:0] A_VEC = BASE + 32'd12;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  irq_src;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        int_take;
    logic        int_req;
    logic [5:0]  hw_int;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] rd_val;

    intc_seq #(.NSRC(6), .BASE_ADDR(BASE)) dut (
        .clk      (clk),
        .reset    (reset),
        .irq_src  (irq_src),
        .addr     (addr),
        .we       (we),
        .wdata    (wdata),
        .rdata    (rdata),
        .int_take (int_take),
        .int_req  (int_req),
        .hw_int   (hw_int)
    );

    always #5 clk = ~clk;

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d = rdata;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        @(negedge clk);
        we    = 1'b0;
    endtask

    task automatic pulse_take();
        int_take = 1'b1;
        @(negedge clk);
        int_take = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++;
        if (int_req !== 1'b0 || hw_int !== 6'd0) begin
            n_fail++;
            $display("FAIL reset_out: int_req=%0b hw_int=%b expected 0/000000", int_req, hw_int);
        end
        rd(A_MSK, rd_val);
        n_checks++;
        if (rd_val !== 32'h3F) begin
            n_fail++;
            $display("FAIL reset_mask: got %h expected 0000003f", rd_val);
        end
        rd(A_PND, rd_val);
        n_checks++;
        if (rd_val !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_pend: got %h expected 00000000", rd_val);
        end
        rd(A_VEC, rd_val);
        n_checks++;
        if (rd_val !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_vec: got %h expected 00000000", rd_val);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (int_req !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: int_req=%0b expected 0", int_req);
        end
    endtask

`ifndef INTC_LEVEL_EN
    task automatic test_basic();
        irq_src = 6'b000100;
        @(negedge clk);
        irq_src = 6'b0;
        n_checks++;
        if (int_req !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_latency1: int_req=%0b expected 0", int_req);
        end
        @(negedge clk);
        n_checks++;
        if (int_req !== 1'b1 || hw_int !== 6'b000100) begin
            n_fail++;
            $display("FAIL basic_req: int_req=%0b hw_int=%b expected 1/000100", int_req, hw_int);
        end
        rd(A_PND, rd_val);
        n_checks++;
        if (rd_val !== 32'h4) begin
            n_fail++;
            $display("FAIL basic_pend: got %h expected 00000004", rd_val);
        end
        pulse_take();
        n_checks++;
        if (int_req !== 1'b0 || hw_int !== 6'd0) begin
            n_fail++;
            $display("FAIL basic_take: int_req=%0b hw_int=%b expected 0/000000", int_req, hw_int);
        end
        rd(A_VEC, rd_val);
        n_checks++;
        if (rd_val !== 32'h8000_0002) begin
            n_fail++;
            $display("FAIL basic_vec_service: got %h expected 80000002", rd_val);
        end
        wr(A_ACK, 32'h0);
        rd(A_VEC, rd_val);
        n_checks++;
        if (rd_val !== 32'h0) begin
            n_fail++;
            $display("FAIL basic_vec_ack: got %h expected 00000000", rd_val);
        end
        rd(A_PND, rd_val);
        n_checks++;
        if (rd_val !== 32'h0) begin
            n_fail++;
            $display("FAIL basic_pend_ack: got %h expected 00000000", rd_val);
        end
        @(negedge clk);
        n_checks++;
        if (int_req !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_idle: int_req=%0b expected 0", int_req);
        end
    endtask

    task automatic test_priority();
        irq_src = 6'b010010;
        @(negedge clk);
        irq_src = 6'b0;
        @(negedge clk);
        n_checks++;
        if (int_req !== 1'b1 || hw_int !== 6'b000010) begin
            n_fail++;
            $display("FAIL prio_first: int_req=%0b hw_int=%b expected 1/000010", int_req, hw_int);
        end
        pulse_take();
        wr(A_ACK, 32'h0);
        n_checks++;
        if (int_req !== 1'b0) begin
            n_fail++;
            $display("FAIL prio_ack_edge: int_req=%0b expected 0", int_req);
        end
        @(negedge clk);
        n_checks++;
        if (int_req !== 1'b1 || hw_int !== 6'b010000) begin
            n_fail++;
            $display("FAIL prio_second: int_req=%0b hw_int=%b expected 1/010000", int_req, hw_int);
        end
        pulse_take();
        wr(A_ACK, 32'h0);
        rd(A_PND, rd_val);
        n_checks++;
        if (rd_val !== 32'h0) begin
            n_fail++;
            $display("FAIL prio_pend_clear: got %h expected 00000000", rd_val);
        end
    endtask

    task automatic test_mask_withdraw();
        irq_src = 6'b000100;
        @(negedge clk);
        irq_src = 6'b0;
        @(negedge clk);
        wr(A_MSK, 32'h3B);
        @(negedge clk);
        n_checks++;
        if (int_req !== 1'b0 || hw_int !== 6'd0) begin
            n_fail++;
            $display("FAIL mask_withdraw: int_req=%0b hw_int=%b expected 0/000000", int_req, hw_int);
        end
        rd(A_PND, rd_val);
        n_checks++;
        if (rd_val !== 32'h4) begin
            n_fail++;
            $display("FAIL mask_pend_kept: got %h expected 00000004", rd_val);
        end
        wr(A_MSK, 32'h3F);
        @(negedge clk);
        n_checks++;
        if (int_req !== 1'b1 || hw_int !== 6'b000100) begin
            n_fail++;
            $display("FAIL mask_return: int_req=%0b hw_int=%b expected 1/000100", int_req, hw_int);
        end
        pulse_take();
        wr(A_ACK, 32'h0);
    endtask

    task automatic test_back_to_back();
        irq_src = 6'b000100;
        @(negedge clk);
        irq_src = 6'b0;
        @(negedge clk);
        pulse_take();
        // New rise of source 2 on the ACK edge.
        addr    = A_ACK;
        wdata   = 32'h0;
        we      = 1'b1;
        irq_src = 6'b000100;
        @(negedge clk);
        we      = 1'b0;
        irq_src = 6'b0;
        rd(A_PND, rd_val);
        n_checks++;
        if (rd_val !== 32'h4) begin
            n_fail++;
            $display("FAIL race_ack_set: got %h expected 00000004", rd_val);
        end
        @(negedge clk);
        n_checks++;
        if (int_req !== 1'b1 || hw_int !== 6'b000100) begin
            n_fail++;
            $display("FAIL race_rerequest: int_req=%0b hw_int=%b expected 1/000100", int_req, hw_int);
        end
        wr(A_PND, 32'h4);
        @(negedge clk);
        n_checks++;
        if (int_req !== 1'b0) begin
            n_fail++;
            $display("FAIL w1c_src2_withdraw: int_req=%0b expected 0", int_req);
        end
        irq_src = 6'b001000;
        @(negedge clk);
        irq_src = 6'b0;
        @(negedge clk);
        n_checks++;
        if (int_req !== 1'b1 || hw_int !== 6'b001000) begin
            n_fail++;
            $display("FAIL w1c_src3_req: int_req=%0b hw_int=%b expected 1/001000", int_req, hw_int);
        end
        wr(A_PND, 32'h8);
        @(negedge clk);
        n_checks++;
        if (int_req !== 1'b0) begin
            n_fail++;
            $display("FAIL w1c_src3_withdraw: int_req=%0b expected 0", int_req);
        end
        rd(A_PND, rd_val);
        n_checks++;
        if (rd_val !== 32'h0) begin
            n_fail++;
            $display("FAIL w1c_pend: got %h expected 00000000", rd_val);
        end
    endtask

    task automatic test_ignored();
        wr(A_MSK, 32'h0);
        irq_src = 6'b100000;
        @(negedge clk);
        irq_src = 6'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (int_req !== 1'b0) begin
            n_fail++;
            $display("FAIL masked_no_req: int_req=%0b expected 0", int_req);
        end
        wr(A_ACK, 32'h0);
        rd(A_PND, rd_val);
        n_checks++;
        if (rd_val !== 32'h20) begin
            n_fail++;
            $display("FAIL idle_ack_ignored: got %h expected 00000020", rd_val);
        end
        pulse_take();
        rd(A_VEC, rd_val);
        n_checks++;
        if (rd_val !== 32'h0 || int_req !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_take_ignored: vec=%h int_req=%0b expected 00000000/0", rd_val, int_req);
        end
        wr(A_MSK, 32'h20);
        @(negedge clk);
        n_checks++;
        if (int_req !== 1'b1 || hw_int !== 6'b100000) begin
            n_fail++;
            $display("FAIL unmask_req: int_req=%0b hw_int=%b expected 1/100000", int_req, hw_int);
        end
        pulse_take();
        rd(A_VEC, rd_val);
        n_checks++;
        if (rd_val !== 32'h8000_0005) begin
            n_fail++;
            $display("FAIL service_vec5: got %h expected 80000005", rd_val);
        end
    endtask

    task automatic test_reset_mid();
        reset = 1'b1;
        #1;
        n_checks++;
        if (int_req !== 1'b0 || hw_int !== 6'd0) begin
            n_fail++;
            $display("FAIL midreset_out: int_req=%0b hw_int=%b expected 0/000000", int_req, hw_int);
        end
        rd(A_MSK, rd_val);
        n_checks++;
        if (rd_val !== 32'h3F) begin
            n_fail++;
            $display("FAIL midreset_mask: got %h expected 0000003f", rd_val);
        end
        rd(A_VEC, rd_val);
        n_checks++;
        if (rd_val !== 32'h0) begin
            n_fail++;
            $display("FAIL midreset_vec: got %h expected 00000000", rd_val);
        end
        rd(A_PND, rd_val);
        n_checks++;
        if (rd_val !== 32'h0) begin
            n_fail++;
            $display("FAIL midreset_pend: got %h expected 00000000", rd_val);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask
`else
    task automatic test_level();
        irq_src = 6'b000001;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (int_req !== 1'b1 || hw_int !== 6'b000001) begin
            n_fail++;
            $display("FAIL level_req: int_req=%0b hw_int=%b expected 1/000001", int_req, hw_int);
        end
        pulse_take();
        wr(A_ACK, 32'h0);
        n_checks++;
        if (int_req !== 1'b0) begin
            n_fail++;
            $display("FAIL level_ack_edge: int_req=%0b expected 0", int_req);
        end
        @(negedge clk);
        n_checks++;
        if (int_req !== 1'b1 || hw_int !== 6'b000001) begin
            n_fail++;
            $display("FAIL level_reassert: int_req=%0b hw_int=%b expected 1/000001", int_req, hw_int);
        end
        pulse_take();
        irq_src = 6'b0;
        @(negedge clk);
        wr(A_ACK, 32'h0);
        @(negedge clk);
        n_checks++;
        if (int_req !== 1'b0) begin
            n_fail++;
            $display("FAIL level_no_reassert1: int_req=%0b expected 0", int_req);
        end
        @(negedge clk);
        n_checks++;
        if (int_req !== 1'b0) begin
            n_fail++;
            $display("FAIL level_no_reassert2: int_req=%0b expected 0", int_req);
        end
    endtask
`endif

    initial begin
        reset    = 1'b1;
        irq_src  = 6'b0;
        addr     = 32'h0;
        we       = 1'b0;
        wdata    = 32'h0;
        int_take = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
`ifndef INTC_LEVEL_EN
        test_basic();
        test_priority();
        test_mask_withdraw();
        test_back_to_back();
        test_ignored();
        test_reset_mid();
`else
        test_level();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
